fetch_stage: RTL and testbench

//  IF stage of the pipelined CPU. Owns the PC and drives the word address into the

---
 rtl/cpu_defs.sv | 15 +
 rtl/ifid_reg.sv | 46 ++++
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath width, opcode field slice, halt opcode,
// bubble encoding, exception vector and fetch FSM state encodings.
package cpu_defs;
  localparam int          BIT_WIDTH  = 32;
  localparam int          OP_MSB     = 31;
  localparam int          OP_LSB     = 26;
  localparam logic [5:0]  HLT_OPCODE = 6'h3F;
  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam int          EXC_VECTOR = 254;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: holds (valid, pc, inst).
//  clk, rst      : clock, async active-high reset
//  load_i        : capture pc_i/inst_i as a valid instruction
//  flush_i       : insert a bubble (wins over load_i)
//  pc_i, inst_i  : incoming fetch
//  valid_o, pc_o, inst_o : registered contents
// With neither load_i nor flush_i the contents hold (stall).
module ifid_reg
  import cpu_defs::*;
#(
  parameter int          W   = BIT_WIDTH,
  parameter logic [31:0] NOP = NOP_INST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         flush_i,
  input  logic [W-1:0] pc_i,
  input  logic [W-1:0] inst_i,
  output logic         valid_o,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] inst_o
);
  logic         valid_q;
  logic [W-1:0] pc_q, inst_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= W'(NOP);
    end else if (flush_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= W'(NOP);
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      inst_q  <= inst_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the word PC, drives the combinational IM, fills IF/ID.
// Handles stalls, EX redirects, hlt detection and out-of-range fetch traps.
//  clk, rst                         : clock, async active-high reset
//  stall                            : hold PC, IF/ID, FSM and count
//  redirect_valid, redirect_target  : taken branch/jump from EX (beats stall)
//  im_addr / im_data                : IM address (= PC) and same-cycle data
//  ifid_pc, ifid_inst, ifid_valid   : IF/ID register contents
//  halted                           : FSM is in HALTED
//  exc_oob                          : one-cycle pulse after an out-of-range fetch
//  fetch_count                      : instructions accepted into IF/ID (wraps)
module fetch_stage
  import cpu_defs::*;
#(
  parameter int bit_width  = BIT_WIDTH,
  parameter int IM_DEPTH   = 1024,
  parameter int RESET_PC   = 0,
  parameter int EXC_VEC    = EXC_VECTOR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [bit_width-1:0] redirect_target,
  output logic [bit_width-1:0] im_addr,
  input  logic [bit_width-1:0] im_data,
  output logic [bit_width-1:0] ifid_pc,
  output logic [bit_width-1:0] ifid_inst,
  output logic                 ifid_valid,
  output logic                 halted,
  output logic                 exc_oob,
  output logic [bit_width-1:0] fetch_count
);
  localparam logic [bit_width-1:0] DEPTH_W = bit_width'(IM_DEPTH);
  localparam logic [bit_width-1:0] RST_PC  = bit_width'(RESET_PC);
  localparam logic [bit_width-1:0] EXC_PC  = bit_width'(EXC_VEC);
  localparam logic [bit_width-1:0] ONE     = bit_width'(1);

  fetch_state_e         state_q, state_d;
  logic [bit_width-1:0] pc_q, pc_d, cnt_q, cnt_d;
  logic                 exc_q, exc_d;
  logic                 oob, is_hlt, ifid_load, ifid_flush;

  // Full-width compare: a PC past the IM must trap, not alias via addr[9:0].
  assign oob    = (pc_q >= DEPTH_W);
  assign is_hlt = (im_data[OP_MSB:OP_LSB] == HLT_OPCODE);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    exc_d      = 1'b0;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (redirect_valid) begin
      // Also cancels a hlt fetched down the wrong path.
      pc_d       = redirect_target;
      state_d    = RUN;
      ifid_flush = 1'b1;
    end else if (!stall) begin
      if (state_q == HALTED) begin
        ifid_flush = 1'b1;
      end else if (oob) begin
        pc_d       = EXC_PC;
        exc_d      = 1'b1;
        ifid_flush = 1'b1;
      end else begin
        ifid_load = 1'b1;
        cnt_d     = cnt_q + ONE;
        if (is_hlt) state_d = HALTED;  // PC parks on the hlt
        else        pc_d    = pc_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RST_PC;
      cnt_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
    end
  end

  ifid_reg #(.W(bit_width), .NOP(NOP_INST)) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .pc_i    (pc_q),
    .inst_i  (im_data),
    .valid_o (ifid_valid),
    .pc_o    (ifid_pc),
    .inst_o  (ifid_inst)
  );

  assign im_addr     = pc_q;
  assign halted      = (state_q == HALTED);
  assign exc_oob     = exc_q;
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_target, im_addr, im_data, ifid_pc, ifid_inst, fetch_count;
  logic        ifid_valid, halted, exc_oob;
  logic [31:0] mem [0:1023];
  int          tests = 0, fails = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .im_addr(im_addr), .im_data(im_data),
    .ifid_pc(ifid_pc), .ifid_inst(ifid_inst), .ifid_valid(ifid_valid),
    .halted(halted), .exc_oob(exc_oob), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign im_data = mem[im_addr[9:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]    = 32'h2001_0001;  // addi words
    mem[1]    = 32'h2002_0002;
    mem[2]    = 32'h2003_0003;
    mem[3]    = 32'h2004_0004;
    mem[5]    = 32'hFC00_0000;  // hlt
    mem[8]    = 32'h2008_0008;
    mem[40]   = 32'h2028_0028;
    mem[254]  = 32'h20FE_00FE;
    mem[1023] = 32'h23FF_03FF;

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    #3;
    chk("rst_addr", im_addr, 0);
    chk("rst_valid", {31'b0, ifid_valid}, 0);
    chk("rst_inst", ifid_inst, 0);
    chk("rst_pc", ifid_pc, 0);
    chk("rst_halt", {31'b0, halted}, 0);
    chk("rst_exc", {31'b0, exc_oob}, 0);
    chk("rst_cnt", fetch_count, 0);
    step(); rst = 1'b0;

    // 1: straight-line fetch 0..3
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", im_addr, 32'(i));
      step();
      chk("t1_pc", ifid_pc, 32'(i));
      chk("t1_inst", ifid_inst, mem[i]);
      chk("t1_valid", {31'b0, ifid_valid}, 1);
    end
    chk("t1_cnt", fetch_count, 4);

    // 2: stall with PC=2, IF/ID holding PC1
    redirect_valid = 1'b1; redirect_target = 1; step();
    redirect_valid = 1'b0; step();
    chk("t2_pre_pc", ifid_pc, 1);
    chk("t2_pre_addr", im_addr, 2);
    stall = 1'b1;
    step(); step();
    chk("t2_addr", im_addr, 2);
    chk("t2_pc", ifid_pc, 1);
    chk("t2_inst", ifid_inst, mem[1]);
    chk("t2_cnt", fetch_count, 5);
    stall = 1'b0; step();
    chk("t2_res_pc", ifid_pc, 2);
    chk("t2_res_inst", ifid_inst, mem[2]);
    chk("t2_res_cnt", fetch_count, 6);

    // 3: redirect beats stall
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 40; step();
    stall = 1'b0; redirect_valid = 1'b0;
    chk("t3_addr", im_addr, 40);
    chk("t3_valid", {31'b0, ifid_valid}, 0);
    chk("t3_inst", ifid_inst, 0);
    chk("t3_cnt", fetch_count, 6);
    step();
    chk("t3_pc", ifid_pc, 40);
    chk("t3_inst40", ifid_inst, 32'h2028_0028);
    chk("t3_cnt2", fetch_count, 7);

    // 4: hlt at 5, then redirect to 8
    redirect_valid = 1'b1; redirect_target = 4; step();
    redirect_valid = 1'b0; step(); step();
    chk("t4_pc", ifid_pc, 5);
    chk("t4_inst", ifid_inst, 32'hFC00_0000);
    chk("t4_valid", {31'b0, ifid_valid}, 1);
    chk("t4_halt", {31'b0, halted}, 1);
    chk("t4_addr", im_addr, 5);
    chk("t4_cnt", fetch_count, 9);
    step();
    chk("t4_bub_valid", {31'b0, ifid_valid}, 0);
    chk("t4_bub_addr", im_addr, 5);
    chk("t4_bub_cnt", fetch_count, 9);
    redirect_valid = 1'b1; redirect_target = 8; step();
    redirect_valid = 1'b0;
    chk("t4_unhalt", {31'b0, halted}, 0);
    chk("t4_addr8", im_addr, 8);
    step();
    chk("t4_pc8", ifid_pc, 8);
    chk("t4_valid8", {31'b0, ifid_valid}, 1);
    chk("t4_cnt8", fetch_count, 10);

    // 5: last word fetches, next one traps
    redirect_valid = 1'b1; redirect_target = 1023; step();
    redirect_valid = 1'b0;
    chk("t5_addr", im_addr, 1023);
    step();
    chk("t5_pc", ifid_pc, 1023);
    chk("t5_inst", ifid_inst, 32'h23FF_03FF);
    chk("t5_exc0", {31'b0, exc_oob}, 0);
    chk("t5_addr1024", im_addr, 1024);
    step();
    chk("t5_exc", {31'b0, exc_oob}, 1);
    chk("t5_valid", {31'b0, ifid_valid}, 0);
    chk("t5_vec", im_addr, 254);
    chk("t5_cnt", fetch_count, 11);
    step();
    chk("t5_exc_pulse", {31'b0, exc_oob}, 0);
    chk("t5_pc254", ifid_pc, 254);
    chk("t5_cnt2", fetch_count, 12);

    // 6: async reset between edges at PC=7
    redirect_valid = 1'b1; redirect_target = 7; step();
    redirect_valid = 1'b0;
    chk("t6_addr7", im_addr, 7);
    #2 rst = 1'b1;
    #1;
    chk("t6_addr", im_addr, 0);
    chk("t6_valid", {31'b0, ifid_valid}, 0);
    chk("t6_cnt", fetch_count, 0);
    chk("t6_inst", ifid_inst, 0);
    step(); #2 rst = 1'b0;
    step();
    chk("t6_pc0", ifid_pc, 0);
    chk("t6_inst0", ifid_inst, mem[0]);
    chk("t6_addr1", im_addr, 1);
    chk("t6_cnt1", fetch_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
